data_mem_responder: RTL and testbench

//  Responder (memory) end of the processor data-memory interface.
//  - Services the requests the processor issues on MemAddr/MemRead/MemWrite/WriteData.
//  - Returns read data with a configurable number of wait states.
//  - Signals completion with a one-cycle Ready pulse.
//  - Replaces the zero-latency behavioural memory so stall logic can be exercised.

---
 rtl/data_mem_responder.sv | 87 ++++++++
 tb/tb_data_mem_responder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Memory end of the processor data-memory interface: word-addressed array with
// a programmable number of wait states and a one-cycle Ready/Error completion pulse.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic        ReadEn,
  input  logic        WriteEn,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam bit DIRECT = (LATENCY == 1);
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   capAddr, capData;
  logic          capWrite;
  logic [31:0]   mem [DEPTH];

  logic          req, enterDone, opWrite, opLegal, memWe;
  logic [31:0]   opAddr, opData;
  logic [AW-1:0] opIdx;

  assign req = ReadEn | WriteEn;

  // With a single wait state the commit happens on the capture edge itself,
  // so the operand mux falls through to the live inputs while IDLE.
  assign opAddr    = (state == IDLE) ? Address   : capAddr;
  assign opData    = (state == IDLE) ? WriteData : capData;
  assign opWrite   = (state == IDLE) ? WriteEn   : capWrite;
  assign opIdx     = opAddr[AW+1:2];
  assign opLegal   = (opAddr[1:0] == 2'b00) && (opAddr < LIMIT);
  assign enterDone = (DIRECT && state == IDLE && req) ||
                     (state == BUSY && cnt == CW'(1));
  assign memWe     = enterDone && opWrite && opLegal && !Reset;

  // Array has no reset; an aborted write never reaches it because memWe is gated.
  always_ff @(posedge Clock) begin
    if (memWe) mem[opIdx] <= opData;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      capAddr  <= '0;
      capData  <= '0;
      capWrite <= 1'b0;
      Ready    <= 1'b0;
      Error    <= 1'b0;
      ReadData <= '0;
    end else begin
      Ready <= 1'b0;
      Error <= 1'b0;
      case (state)
        IDLE: if (req) begin
          capAddr  <= Address;
          capData  <= WriteData;
          capWrite <= WriteEn;
          cnt      <= CW'(LATENCY - 1);
          state    <= DIRECT ? DONE : BUSY;
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enterDone) begin
        Ready <= 1'b1;
        Error <= !opLegal;
        if (!opWrite) ReadData <= opLegal ? mem[opIdx] : 32'h0;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: table of single accesses on a LATENCY=2 instance, a reset-abort
// sequence, and held-request pulse spacing on LATENCY=1 and LATENCY=4 instances.
module tb_data_mem_responder;
  logic        Clock, Reset;
  logic [31:0] Address, WriteData, ReadData;
  logic        ReadEn, WriteEn, Ready, Error;
  logic        rd1, rd4, rdy1, rdy4, err1, err4;
  logic [31:0] data1, data4;
  logic [31:0] zero32;

  int total = 0, passed = 0;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .Clock(Clock), .Reset(Reset), .Address(Address), .ReadEn(ReadEn),
    .WriteEn(WriteEn), .WriteData(WriteData), .ReadData(ReadData),
    .Ready(Ready), .Error(Error));

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Address(zero32), .ReadEn(rd1),
    .WriteEn(1'b0), .WriteData(zero32), .ReadData(data1),
    .Ready(rdy1), .Error(err1));

  data_mem_responder #(.DEPTH(256), .LATENCY(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .Address(zero32), .ReadEn(rd4),
    .WriteEn(1'b0), .WriteData(zero32), .ReadData(data4),
    .Ready(rdy4), .Error(err4));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic        expErr;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive one request, hold it until Ready, then drop it. lat counts posedges.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic err,
                        output logic [31:0] rdata, output int lat);
    @(negedge Clock);
    ReadEn = r; WriteEn = w; Address = a; WriteData = d;
    lat = 0;
    do begin
      @(negedge Clock);
      lat++;
    end while (!Ready && lat < 20);
    err = Error; rdata = ReadData;
    ReadEn = 1'b0; WriteEn = 1'b0;
  endtask

  initial begin
    logic        e;
    logic [31:0] rdv;
    int          lat, seen;
    int          cnt1, cnt4, first1, first4, last1, last4, badGap1, badGap4;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'h12345678, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'h12345678};
    vecs[2]  = '{1'b1, 1'b0, 32'h13,  32'h0,        1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0,   32'h00000BEE, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h00000BEE};
    vecs[6]  = '{1'b1, 1'b1, 32'h8,   32'hA5A5A5A5, 1'b0, 32'h00000BEE};
    vecs[7]  = '{1'b1, 1'b0, 32'h8,   32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[8]  = '{1'b0, 1'b1, 32'h3FC, 32'h55AA00FF, 1'b0, 32'hA5A5A5A5};
    vecs[9]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'h55AA00FF};
    vecs[10] = '{1'b0, 1'b1, 32'h2,   32'hDEADBEEF, 1'b1, 32'h55AA00FF};
    vecs[11] = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h00000BEE};
    vecs[12] = '{1'b1, 1'b0, 32'h400, 32'h0,        1'b1, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 32'h20,  32'h00000077, 1'b0, 32'h0};

    zero32 = '0;
    Reset = 1'b1; ReadEn = 0; WriteEn = 0; Address = '0; WriteData = '0;
    rd1 = 0; rd4 = 0;
    repeat (2) @(negedge Clock);
    chk("reset Ready", {31'b0, Ready}, 32'h0);
    chk("reset Error", {31'b0, Error}, 32'h0);
    chk("reset ReadData", ReadData, 32'h0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, e, rdv, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d Error", i), {31'b0, e}, {31'b0, vecs[i].expErr});
      chk($sformatf("vec%0d ReadData", i), rdv, vecs[i].expData);
    end

    // Reset while BUSY aborts the write to 0x20.
    @(negedge Clock);
    WriteEn = 1'b1; Address = 32'h20; WriteData = 32'h1;
    @(negedge Clock);
    Reset = 1'b1; WriteEn = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge Clock);
      if (Ready) seen++;
    end
    chk("abort no Ready", 32'(seen), 32'd0);
    chk("abort Error", {31'b0, Error}, 32'h0);
    chk("abort ReadData", ReadData, 32'h0);
    Reset = 1'b0;
    access(1'b1, 1'b0, 32'h20, 32'h0, e, rdv, lat);
    chk("post-abort read", rdv, 32'h00000077);
    chk("post-abort Error", {31'b0, e}, 32'h0);

    // Held reads: pulses every LATENCY+1 cycles.
    @(negedge Clock);
    rd1 = 1'b1; rd4 = 1'b1;
    cnt1 = 0; cnt4 = 0; first1 = -1; first4 = -1; last1 = 0; last4 = 0;
    badGap1 = 0; badGap4 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clock);
      if (rdy1) begin
        if (first1 < 0) first1 = c;
        else if (c - last1 != 2) badGap1++;
        last1 = c; cnt1++;
      end
      if (rdy4) begin
        if (first4 < 0) first4 = c;
        else if (c - last4 != 5) badGap4++;
        last4 = c; cnt4++;
      end
    end
    rd1 = 1'b0; rd4 = 1'b0;
    chk("lat1 first pulse", 32'(first1), 32'd1);
    chk("lat1 pulse count", 32'(cnt1), 32'd10);
    chk("lat1 bad gaps", 32'(badGap1), 32'd0);
    chk("lat4 first pulse", 32'(first4), 32'd4);
    chk("lat4 pulse count", 32'(cnt4), 32'd4);
    chk("lat4 bad gaps", 32'(badGap4), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
